// File: rtl/mac_array_sequencer.sv
// Command sequencer for the MAC array: loads K*K weights from BRAM, then streams
// a programmed number of ifmap words from the FIFO and flags psums as they emerge.
module mac_array_sequencer #(
    parameter int MAC_NUM            = 256,
    parameter int MAX_K              = 5,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int CNT_WIDTH          = 16,
    parameter int BRAM_LAT           = 1,
    parameter int MAC_LAT            = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [4:0]                    kernel_size,
    input  logic [CNT_WIDTH-1:0]          num_ifmaps,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
    input  logic [MAC_NUM-1:0]            enable_in,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
    output logic                          bram_rd_en,
    output logic                          load_weight_preload,
    output logic                          load_MAC_weight,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    output logic                          load_ifmaps,
    output logic [MAC_NUM-1:0]            enable,
    output logic                          psum_valid,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   status
);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, W_WAIT, LOAD_MAC, COMPUTE, DRAIN, FINISH
    } state_t;

    localparam logic [4:0]          K_MAX_V    = 5'(MAX_K);
    localparam logic [7:0]          DRAIN_LAST = 8'(MAC_LAT);
    localparam logic [BRAM_LAT-1:0] WSR_LAST   = BRAM_LAT'(1) << (BRAM_LAT - 1);

    state_t                          state_reg;
    logic [9:0]                      k_sq_reg;
    logic [9:0]                      rd_cnt_reg;
    logic [BRAM_ADDRESS_WIDTH-1:0]   addr_reg;
    logic [CNT_WIDTH-1:0]            remaining_reg;
    logic [MAC_NUM-1:0]              enable_reg;
    logic [7:0]                      drain_cnt_reg;
    logic                            rd_en_reg;
    logic                            load_mac_reg;
    logic                            load_ifmaps_reg;
    logic                            done_reg;
    logic                            done_sticky_reg;
    logic                            err_sticky_reg;
    logic [BRAM_LAT-1:0]             wsr_reg;
    logic [BRAM_LAT-1:0]             wsr_next;
    logic [MAC_LAT-1:0]              psr_reg;
    logic [MAC_LAT-1:0]              psr_next;
    logic                            pop;
    logic                            cmd_legal;

    assign cmd_legal = (kernel_size != 5'd0) && (kernel_size <= K_MAX_V) &&
                       (num_ifmaps != '0);
    assign pop       = (state_reg == COMPUTE) && !fifo_empty && (remaining_reg != '0);

    // Latency lines: BRAM read -> preload strobe, load_ifmaps -> psum_valid.
    assign wsr_next[0] = rd_en_reg;
    assign psr_next[0] = load_ifmaps_reg;
    genvar gi;
    generate
        for (gi = 1; gi < BRAM_LAT; gi++) begin : g_wsr
            assign wsr_next[gi] = wsr_reg[gi-1];
        end
        for (gi = 1; gi < MAC_LAT; gi++) begin : g_psr
            assign psr_next[gi] = psr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            k_sq_reg        <= '0;
            rd_cnt_reg      <= '0;
            addr_reg        <= '0;
            remaining_reg   <= '0;
            enable_reg      <= '0;
            drain_cnt_reg   <= '0;
            rd_en_reg       <= 1'b0;
            load_mac_reg    <= 1'b0;
            load_ifmaps_reg <= 1'b0;
            done_reg        <= 1'b0;
            done_sticky_reg <= 1'b0;
            err_sticky_reg  <= 1'b0;
            wsr_reg         <= '0;
            psr_reg         <= '0;
        end else if (abort) begin
            // Abort flushes in-flight strobes but keeps the sticky status and mask.
            state_reg       <= IDLE;
            rd_en_reg       <= 1'b0;
            load_mac_reg    <= 1'b0;
            load_ifmaps_reg <= 1'b0;
            done_reg        <= 1'b0;
            wsr_reg         <= '0;
            psr_reg         <= '0;
        end else begin
            wsr_reg         <= wsr_next;
            psr_reg         <= psr_next;
            load_ifmaps_reg <= pop;
            load_mac_reg    <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (cmd_legal) begin
                            k_sq_reg        <= 10'(kernel_size) * 10'(kernel_size);
                            rd_cnt_reg      <= '0;
                            addr_reg        <= weight_base_addr;
                            rd_en_reg       <= 1'b1;
                            remaining_reg   <= num_ifmaps;
                            enable_reg      <= enable_in;
                            done_sticky_reg <= 1'b0;
                            err_sticky_reg  <= 1'b0;
                            state_reg       <= LOAD_W;
                        end else begin
                            err_sticky_reg  <= 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (rd_cnt_reg == k_sq_reg - 10'd1) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= W_WAIT;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 10'd1;
                        addr_reg   <= addr_reg + BRAM_ADDRESS_WIDTH'(1);
                    end
                end
                W_WAIT: begin
                    // Last preload is on the output with nothing queued behind it.
                    if (wsr_reg == WSR_LAST) begin
                        load_mac_reg <= 1'b1;
                        state_reg    <= LOAD_MAC;
                    end
                end
                LOAD_MAC: state_reg <= COMPUTE;
                COMPUTE: begin
                    if (pop) begin
                        remaining_reg <= remaining_reg - CNT_WIDTH'(1);
                        if (remaining_reg == CNT_WIDTH'(1)) begin
                            drain_cnt_reg <= '0;
                            state_reg     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 8'd1;
                    end
                end
                FINISH: begin
                    done_sticky_reg <= 1'b1;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bram_addr           = addr_reg;
    assign bram_rd_en          = rd_en_reg;
    assign load_weight_preload = wsr_reg[BRAM_LAT-1];
    assign load_MAC_weight     = load_mac_reg;
    assign fifo_rd_en          = pop;
    assign load_ifmaps         = load_ifmaps_reg;
    assign enable              = enable_reg;
    assign psum_valid          = psr_reg[MAC_LAT-1];
    assign busy                = (state_reg != IDLE);
    assign done                = done_reg;
    assign status              = {29'd0, err_sticky_reg, done_sticky_reg, busy};

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed, table-driven bench for mac_array_sequencer: each row is one command
// with hand-computed pulse counts, addresses and status values.
module tb_mac_array_sequencer;
    localparam int MAC_NUM  = 256;
    localparam int MAX_K    = 5;
    localparam int AW       = 12;
    localparam int CW       = 16;
    localparam int BRAM_LAT = 1;
    localparam int MAC_LAT  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [4:0]         kernel_size = '0;
    logic [CW-1:0]      num_ifmaps = '0;
    logic [AW-1:0]      weight_base_addr = '0;
    logic [MAC_NUM-1:0] enable_in = '0;
    logic [AW-1:0]      bram_addr;
    logic               bram_rd_en;
    logic               load_weight_preload;
    logic               load_MAC_weight;
    logic               fifo_empty = 1'b0;
    logic               fifo_rd_en;
    logic               load_ifmaps;
    logic [MAC_NUM-1:0] enable;
    logic               psum_valid;
    logic               busy;
    logic               done;
    logic [31:0]        status;

    always #5 clk = ~clk;

    mac_array_sequencer #(
        .MAC_NUM(MAC_NUM), .MAX_K(MAX_K), .BRAM_ADDRESS_WIDTH(AW),
        .CNT_WIDTH(CW), .BRAM_LAT(BRAM_LAT), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .kernel_size(kernel_size), .num_ifmaps(num_ifmaps),
        .weight_base_addr(weight_base_addr), .enable_in(enable_in),
        .bram_addr(bram_addr), .bram_rd_en(bram_rd_en),
        .load_weight_preload(load_weight_preload), .load_MAC_weight(load_MAC_weight),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .load_ifmaps(load_ifmaps),
        .enable(enable), .psum_valid(psum_valid), .busy(busy), .done(done),
        .status(status)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_en(input string name, input logic [MAC_NUM-1:0] act,
                            input logic [MAC_NUM-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ev_mode: 0 none, 1 abort on ev_n-th read, 2 abort on ev_n-th pop, 3 rst on ev_n-th pop
    typedef struct {
        int          do_reset;
        int          k;
        int          num;
        int          base;
        logic [31:0] mask;
        int          fifo_mode;
        int          ev_mode;
        int          ev_n;
        int          restart_at;
        int          reads;
        int          pre;
        int          lm;
        int          pops;
        int          li;
        int          ps;
        int          dn;
        int          first_a;
        int          last_a;
        int          st_c1;
        int          st_end;
        int          en_latched;
    } vec_t;

    vec_t vecs[13];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int row, input vec_t v);
        int rd = 0, pre = 0, lm = 0, pops = 0, pop_empty = 0, li = 0, ps = 0, dn = 0;
        int addr_err = 0, pre_lag = 0, li_lag = 0, ps_lag = 0, post_act = 0;
        int first_a = -1, last_a = -1, st_c1 = 0, st_end = 0;
        int last_ps_cyc = -1, done_cyc = -1, ev_cyc = -1, lm_cyc = -1, first_pop_cyc = -1;
        logic prev_rd = 1'b0;
        logic [3:0] pop_hist = '0;
        logic [AW-1:0] exp_a;
        logic [MAC_NUM-1:0] exp_en;
        string tag;
        exp_a = v.base[AW-1:0];
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            start            = (c == 0) || (v.restart_at != 0 && c == v.restart_at);
            kernel_size      = (c == 0) ? v.k[4:0] : 5'd0;
            num_ifmaps       = v.num[CW-1:0];
            weight_base_addr = v.base[AW-1:0];
            enable_in        = (c == 0) ? {8{v.mask}} : '0;
            abort            = 1'b0;
            rst              = 1'b0;
            fifo_empty       = (v.fifo_mode == 1) ? c[0] : 1'b0;
            #1;
            if (ev_cyc >= 0 && c > ev_cyc &&
                (bram_rd_en | load_weight_preload | load_MAC_weight | fifo_rd_en |
                 load_ifmaps | psum_valid | done | busy))
                post_act++;
            if (c == 1) st_c1 = int'(status);
            if (c == 89) st_end = int'(status);
            if (bram_rd_en) begin
                if (first_a < 0) first_a = int'(bram_addr);
                last_a = int'(bram_addr);
                if (bram_addr !== exp_a) addr_err++;
                exp_a = exp_a + 1'b1;
                rd++;
            end
            if (load_weight_preload) begin
                pre++;
                if (!prev_rd) pre_lag++;
            end
            if (load_MAC_weight) begin
                lm++;
                lm_cyc = c;
            end
            if (fifo_rd_en) begin
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = c;
                if (fifo_empty) pop_empty++;
            end
            if (load_ifmaps) begin
                li++;
                if (!pop_hist[0]) li_lag++;
            end
            if (psum_valid) begin
                ps++;
                last_ps_cyc = c;
                if (!pop_hist[2]) ps_lag++;
            end
            if (done) begin
                dn++;
                done_cyc = c;
            end
            if (ev_cyc < 0 && v.ev_mode == 1 && bram_rd_en && rd == v.ev_n) begin
                abort = 1'b1; ev_cyc = c;
            end
            if (ev_cyc < 0 && v.ev_mode == 2 && fifo_rd_en && pops == v.ev_n) begin
                abort = 1'b1; ev_cyc = c;
            end
            if (ev_cyc < 0 && v.ev_mode == 3 && fifo_rd_en && pops == v.ev_n) begin
                rst = 1'b1; ev_cyc = c;
            end
            prev_rd  = bram_rd_en;
            pop_hist = {pop_hist[2:0], fifo_rd_en};
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        exp_en = v.en_latched != 0 ? {8{v.mask}} : '0;
        tag = $sformatf("row%0d", row);
        check({tag, " reads"}, rd, v.reads);
        check({tag, " preloads"}, pre, v.pre);
        check({tag, " preload_lag"}, pre_lag, 0);
        check({tag, " load_mac"}, lm, v.lm);
        check({tag, " pops"}, pops, v.pops);
        check({tag, " pop_while_empty"}, pop_empty, 0);
        check({tag, " load_ifmaps"}, li, v.li);
        check({tag, " load_ifmaps_lag"}, li_lag, 0);
        check({tag, " psum_valid"}, ps, v.ps);
        check({tag, " psum_lag"}, ps_lag, 0);
        check({tag, " done"}, dn, v.dn);
        check({tag, " addr_seq"}, addr_err, 0);
        check({tag, " first_addr"}, first_a, v.first_a);
        check({tag, " last_addr"}, last_a, v.last_a);
        check({tag, " status_c1"}, st_c1, v.st_c1);
        check({tag, " status_end"}, st_end, v.st_end);
        check_en({tag, " enable"}, enable, exp_en);
        if (v.ev_mode != 0) check({tag, " post_event_activity"}, post_act, 0);
        if (v.dn != 0) check({tag, " done_after_last_psum"}, done_cyc - last_ps_cyc, 1);
        if (v.fifo_mode == 0 && v.lm != 0 && v.pops != 0)
            check({tag, " first_pop_after_load_mac"}, first_pop_cyc - lm_cyc, 1);
        $display("row%0d k=%0d num=%0d base=0x%03h: reads=%0d pops=%0d psum=%0d done=%0d status=0x%0h",
                 row, v.k, v.num, v.base, rd, pops, ps, dn, st_end);
    endtask

    initial begin
        //          rst k  num base    mask           fm ev n  rs  rd pre lm pop li ps dn first  last   c1 end en
        vecs[0]  = '{1, 3, 4, 12'h0FE, 32'hA5A5_0001, 0, 0, 0, 0,  9, 9, 1, 4, 4, 4, 1, 'h0FE, 'h106, 1, 2, 1};
        vecs[1]  = '{1, 1, 1, 12'hFFF, 32'h1234_5678, 0, 0, 0, 0,  1, 1, 1, 1, 1, 1, 1, 'hFFF, 'hFFF, 1, 2, 1};
        vecs[2]  = '{1, 2, 2, 12'hFFF, 32'hFFFF_0000, 0, 0, 0, 0,  4, 4, 1, 2, 2, 2, 1, 'hFFF, 'h002, 1, 2, 1};
        vecs[3]  = '{1, 3, 5, 12'h010, 32'h0F0F_0F0F, 1, 0, 0, 0,  9, 9, 1, 5, 5, 5, 1, 'h010, 'h018, 1, 2, 1};
        vecs[4]  = '{1, 5, 3, 12'h100, 32'h0000_0003, 0, 1, 5, 0,  5, 4, 0, 0, 0, 0, 0, 'h100, 'h104, 1, 0, 1};
        vecs[5]  = '{1, 2, 8, 12'h200, 32'h8000_0001, 0, 2, 2, 0,  4, 4, 1, 2, 1, 0, 0, 'h200, 'h203, 1, 0, 1};
        vecs[6]  = '{1, 5, 2, 12'hFFE, 32'h3C3C_3C3C, 1, 0, 0, 0, 25,25, 1, 2, 2, 2, 1, 'hFFE, 'h016, 1, 2, 1};
        vecs[7]  = '{1, 0, 4, 12'h000, 32'hDEAD_BEEF, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, -1,    -1,    4, 4, 0};
        vecs[8]  = '{0, 6, 4, 12'h000, 32'hDEAD_BEEF, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, -1,    -1,    4, 4, 0};
        vecs[9]  = '{0, 2, 3, 12'h050, 32'h5555_AAAA, 0, 0, 0, 3,  4, 4, 1, 3, 3, 3, 1, 'h050, 'h053, 1, 2, 1};
        vecs[10] = '{1, 4, 0, 12'h000, 32'h0000_00FF, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, -1,    -1,    4, 4, 0};
        vecs[11] = '{1, 1, 8, 12'h300, 32'h0000_FFFF, 0, 3, 2, 0,  1, 1, 1, 2, 1, 0, 0, 'h300, 'h300, 1, 0, 0};
        vecs[12] = '{0, 3, 4, 12'h0FE, 32'hA5A5_0001, 0, 0, 0, 0,  9, 9, 1, 4, 4, 4, 1, 'h0FE, 'h106, 1, 2, 1};

        // Reset state
        do_reset();
        #1;
        check("reset bram_addr", int'(bram_addr), 0);
        check("reset bram_rd_en", int'(bram_rd_en), 0);
        check("reset load_weight_preload", int'(load_weight_preload), 0);
        check("reset load_MAC_weight", int'(load_MAC_weight), 0);
        check("reset fifo_rd_en", int'(fifo_rd_en), 0);
        check("reset load_ifmaps", int'(load_ifmaps), 0);
        check("reset psum_valid", int'(psum_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset status", int'(status), 0);
        check_en("reset enable", enable, '0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_reset != 0) do_reset();
            run_vec(i, vecs[i]);
        end

        // Abort and start in the same cycle: the start must be dropped.
        do_reset();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; kernel_size = 5'd2; num_ifmaps = 16'd2;
        weight_base_addr = 12'h123; enable_in = {8{32'hCAFE_F00D}};
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check("abort_start busy", int'(busy), 0);
        check("abort_start bram_rd_en", int'(bram_rd_en), 0);
        check("abort_start status", int'(status), 0);
        check_en("abort_start enable", enable, '0);
        @(negedge clk);
        #1;
        check("abort_start busy_2", int'(busy), 0);
        check("abort_start bram_rd_en_2", int'(bram_rd_en), 0);
        $display("abort+start same cycle: busy=%0d status=0x%0h", busy, status);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
